// File: rtl/store_buffer_if.sv
// Store intake, data-memory bus and load-hazard signals of the store buffer.
// slave = buffer side, master = MEM stage / memory / hazard unit side.
interface store_buffer_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [1:0]    st_op;
  logic [31:0]   st_addr;
  logic [31:0]   st_wdata;
  logic          st_ready;
  logic          align_err;

  logic          m_data_req;
  logic [31:0]   m_data_addr;
  logic [31:0]   m_data_wdata;
  logic [3:0]    m_data_byteen;
  logic          m_data_ack;

  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic          ld_hazard;
  logic [CW-1:0] count;

  modport slave (
    input  st_valid, st_op, st_addr, st_wdata, m_data_ack, ld_valid, ld_addr,
    output st_ready, align_err, m_data_req, m_data_addr, m_data_wdata,
           m_data_byteen, ld_hazard, count
  );

  modport master (
    output st_valid, st_op, st_addr, st_wdata, m_data_ack, ld_valid, ld_addr,
    input  st_ready, align_err, m_data_req, m_data_addr, m_data_wdata,
           m_data_byteen, ld_hazard, count
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: aligns sw/sh/sb requests into word/byte-enable form, queues
// them in a FIFO drained over a req/ack bus, and flags loads to pending words.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [DEPTH-1:0]   r_vld;
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_align_err;

  entry_t             w_enc;
  logic               w_rej, w_push, w_pop, w_req, w_hit;

  // Alignment/encoding of the incoming store
  always_comb begin
    w_rej       = 1'b0;
    w_enc.waddr = bus.st_addr[31:2];
    w_enc.data  = bus.st_wdata;
    w_enc.be    = 4'b1111;
    case (bus.st_op)
      2'b00: w_rej = (bus.st_addr[1:0] != 2'b00);
      2'b01: begin
        w_rej      = bus.st_addr[0];
        w_enc.data = {2{bus.st_wdata[15:0]}};
        w_enc.be   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        w_enc.data = {4{bus.st_wdata[7:0]}};
        w_enc.be   = 4'b0001 << bus.st_addr[1:0];
      end
      default: w_rej = 1'b1;
    endcase
  end

  assign bus.st_ready = (r_count < CW'(DEPTH));
  assign w_req        = (r_count != '0);
  assign w_push       = bus.st_valid && bus.st_ready && !w_rej;
  assign w_pop        = w_req && bus.m_data_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_vld       <= '0;
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= bus.st_valid && w_rej;
      if (w_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + AW'(1);
      end
      // Push and pop never target the same slot: a push with a pop needs 0 < count < DEPTH
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_enc;
  end

  // Head entry popped this cycle is still valid here, so the hazard stays conservative
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (r_vld[i] && (r_mem[i].waddr == bus.ld_addr[31:2])) w_hit = 1'b1;
  end

  assign bus.ld_hazard     = bus.ld_valid && w_hit;
  assign bus.align_err     = r_align_err;
  assign bus.count         = r_count;
  assign bus.m_data_req    = w_req;
  assign bus.m_data_addr   = w_req ? {r_mem[r_rptr].waddr, 2'b00} : 32'h0;
  assign bus.m_data_wdata  = w_req ? r_mem[r_rptr].data : 32'h0;
  assign bus.m_data_byteen = w_req ? r_mem[r_rptr].be : 4'h0;
endmodule

// File: tb/tb_store_buffer.sv
// Directed checks of the store buffer: encoding, rejection, fill/drain order,
// load hazard, simultaneous push/pop and reset while entries are pending.
module tb_store_buffer;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  store_buffer_if #(.DEPTH(4)) bus();
  store_buffer #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.st_valid = 1'b0; bus.st_op = 2'b00; bus.st_addr = 32'h0; bus.st_wdata = 32'h0;
    bus.m_data_ack = 1'b0; bus.ld_valid = 1'b0; bus.ld_addr = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.m_data_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.m_data_req); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.st_ready); end
    checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL reset_align got=%b exp=0", bus.align_err); end
    checks++; if (bus.m_data_addr !== 32'h0 || bus.m_data_byteen !== 4'h0 || bus.m_data_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_head got=%h/%h/%b exp=0", bus.m_data_addr, bus.m_data_wdata, bus.m_data_byteen); end
  endtask

  task automatic test_sb();
    bus.st_valid = 1'b1; bus.st_op = 2'b10; bus.st_addr = 32'h0000_1003; bus.st_wdata = 32'h1234_56AB;
    bus.m_data_ack = 1'b1;
    @(negedge clk);
    bus.st_valid = 1'b0;
    checks++; if (bus.m_data_req !== 1'b1) begin errors++; $display("FAIL sb_req got=%b exp=1", bus.m_data_req); end
    checks++; if (bus.m_data_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got=%h exp=00001000", bus.m_data_addr); end
    checks++; if (bus.m_data_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got=%h exp=ababab ab", bus.m_data_wdata); end
    checks++; if (bus.m_data_byteen !== 4'b1000) begin errors++; $display("FAIL sb_byteen got=%b exp=1000", bus.m_data_byteen); end
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL sb_count got=%0d exp=1", bus.count); end
    @(negedge clk);
    bus.m_data_ack = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL sb_drained got=%0d exp=0", bus.count); end
    checks++; if (bus.m_data_req !== 1'b0 || bus.m_data_addr !== 32'h0) begin
      errors++; $display("FAIL sb_empty_head got=%b/%h exp=0/0", bus.m_data_req, bus.m_data_addr); end
  endtask

  task automatic test_sh();
    bus.st_valid = 1'b1; bus.st_op = 2'b01; bus.st_addr = 32'h0000_2002; bus.st_wdata = 32'hFFFF_BEEF;
    @(negedge clk);
    bus.st_valid = 1'b0;
    checks++; if (bus.m_data_byteen !== 4'b1100) begin errors++; $display("FAIL sh_byteen got=%b exp=1100", bus.m_data_byteen); end
    checks++; if (bus.m_data_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got=%h exp=beefbeef", bus.m_data_wdata); end
    checks++; if (bus.m_data_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr got=%h exp=00002000", bus.m_data_addr); end
    @(negedge clk);
    checks++; if (bus.m_data_byteen !== 4'b1100 || bus.m_data_req !== 1'b1) begin
      errors++; $display("FAIL sh_hold got=%b/%b exp=1/1100", bus.m_data_req, bus.m_data_byteen); end
    bus.m_data_ack = 1'b1;
    @(negedge clk);
    bus.m_data_ack = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL sh_drained got=%0d exp=0", bus.count); end
    // low-half sh and sb at byte 1
    bus.st_valid = 1'b1; bus.st_op = 2'b01; bus.st_addr = 32'h0000_2100; bus.st_wdata = 32'h0000_1357;
    @(negedge clk);
    bus.st_op = 2'b10; bus.st_addr = 32'h0000_2101; bus.st_wdata = 32'h0000_00C3;
    checks++; if (bus.m_data_byteen !== 4'b0011 || bus.m_data_wdata !== 32'h1357_1357) begin
      errors++; $display("FAIL sh_low got=%b/%h exp=0011/13571357", bus.m_data_byteen, bus.m_data_wdata); end
    bus.m_data_ack = 1'b1;
    @(negedge clk);
    bus.st_valid = 1'b0;
    checks++; if (bus.m_data_byteen !== 4'b0010 || bus.m_data_wdata !== 32'hC3C3_C3C3 || bus.count !== 3'd1) begin
      errors++; $display("FAIL sb_byte1 got=%b/%h/%0d exp=0010/c3c3c3c3/1", bus.m_data_byteen, bus.m_data_wdata, bus.count); end
    @(negedge clk);
    bus.m_data_ack = 1'b0;
  endtask

  task automatic test_reject();
    bus.st_valid = 1'b1; bus.st_op = 2'b00; bus.st_addr = 32'h0000_3001; bus.st_wdata = 32'h5555_5555;
    @(negedge clk);
    bus.st_valid = 1'b0;
    checks++; if (bus.align_err !== 1'b1) begin errors++; $display("FAIL rej_align got=%b exp=1", bus.align_err); end
    checks++; if (bus.count !== 3'd0 || bus.m_data_req !== 1'b0) begin
      errors++; $display("FAIL rej_nopush got=%0d/%b exp=0/0", bus.count, bus.m_data_req); end
    @(negedge clk);
    checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL rej_width got=%b exp=0", bus.align_err); end
    bus.st_valid = 1'b1; bus.st_op = 2'b11; bus.st_addr = 32'h0000_3000;
    @(negedge clk);
    bus.st_op = 2'b01; bus.st_addr = 32'h0000_3003;
    checks++; if (bus.align_err !== 1'b1 || bus.count !== 3'd0) begin
      errors++; $display("FAIL rej_op11 got=%b/%0d exp=1/0", bus.align_err, bus.count); end
    @(negedge clk);
    bus.st_valid = 1'b0;
    checks++; if (bus.align_err !== 1'b1 || bus.count !== 3'd0) begin
      errors++; $display("FAIL rej_sh_odd got=%b/%0d exp=1/0", bus.align_err, bus.count); end
    @(negedge clk);
  endtask

  task automatic test_hazard();
    bus.st_valid = 1'b1; bus.st_op = 2'b00; bus.st_addr = 32'h14; bus.st_wdata = 32'h14;
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h16;
    checks++; if (bus.ld_hazard !== 1'b0) begin errors++; $display("FAIL hz_samecycle got=%b exp=0", bus.ld_hazard); end
    @(negedge clk);
    bus.st_valid = 1'b0;
    checks++; if (bus.ld_hazard !== 1'b1) begin errors++; $display("FAIL hz_hit got=%b exp=1", bus.ld_hazard); end
    bus.ld_addr = 32'h18;
    #1;
    checks++; if (bus.ld_hazard !== 1'b0) begin errors++; $display("FAIL hz_miss got=%b exp=0", bus.ld_hazard); end
    bus.ld_addr = 32'h14; bus.ld_valid = 1'b0;
    #1;
    checks++; if (bus.ld_hazard !== 1'b0) begin errors++; $display("FAIL hz_novalid got=%b exp=0", bus.ld_hazard); end
    bus.ld_valid = 1'b1; bus.m_data_ack = 1'b1;
    #1;
    checks++; if (bus.ld_hazard !== 1'b1) begin errors++; $display("FAIL hz_popping got=%b exp=1", bus.ld_hazard); end
    @(negedge clk);
    bus.m_data_ack = 1'b0;
    checks++; if (bus.ld_hazard !== 1'b0 || bus.count !== 3'd0) begin
      errors++; $display("FAIL hz_after_pop got=%b/%0d exp=0/0", bus.ld_hazard, bus.count); end
    bus.ld_valid = 1'b0;
  endtask

  task automatic test_push_pop();
    bus.st_valid = 1'b1; bus.st_op = 2'b00; bus.st_addr = 32'h100; bus.st_wdata = 32'hA;
    @(negedge clk);
    bus.st_addr = 32'h104; bus.st_wdata = 32'hB; bus.m_data_ack = 1'b1;
    @(negedge clk);
    bus.st_valid = 1'b0;
    checks++; if (bus.count !== 3'd1 || bus.m_data_addr !== 32'h104 || bus.m_data_wdata !== 32'hB) begin
      errors++; $display("FAIL pushpop got=%0d/%h/%h exp=1/104/b", bus.count, bus.m_data_addr, bus.m_data_wdata); end
    @(negedge clk);
    bus.m_data_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.st_valid = 1'b1; bus.st_op = 2'b00;
    for (int i = 0; i < 4; i++) begin
      bus.st_addr = 32'h10 + 32'(4 * i); bus.st_wdata = 32'hD000 + 32'(i);
      @(negedge clk);
    end
    checks++; if (bus.st_ready !== 1'b0 || bus.count !== 3'd4) begin
      errors++; $display("FAIL fill got=%b/%0d exp=0/4", bus.st_ready, bus.count); end
    bus.st_addr = 32'h20; bus.st_wdata = 32'hEEEE;
    @(negedge clk);
    checks++; if (bus.count !== 3'd4 || bus.m_data_addr !== 32'h10) begin
      errors++; $display("FAIL fill_5th got=%0d/%h exp=4/10", bus.count, bus.m_data_addr); end
    // full + pop + push: not ready this cycle, so the push is dropped
    bus.st_addr = 32'h40; bus.m_data_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.m_data_req !== 1'b1 || bus.m_data_addr !== 32'h10 + 32'(4 * i) || bus.m_data_wdata !== 32'hD000 + 32'(i)) begin
        errors++; $display("FAIL drain%0d got=%b/%h/%h exp=1/%h/%h", i, bus.m_data_req, bus.m_data_addr,
                           bus.m_data_wdata, 32'h10 + 32'(4 * i), 32'hD000 + 32'(i)); end
      @(negedge clk);
      bus.st_valid = 1'b0;
    end
    checks++; if (bus.count !== 3'd0 || bus.m_data_req !== 1'b0) begin
      errors++; $display("FAIL drain_end got=%0d/%b exp=0/0", bus.count, bus.m_data_req); end
    bus.m_data_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.st_valid = 1'b1; bus.st_op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      bus.st_addr = 32'h80 + 32'(4 * i); bus.st_wdata = 32'(i);
      @(negedge clk);
    end
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL mid_prefill got=%0d exp=3", bus.count); end
    reset = 1'b1; bus.m_data_ack = 1'b1; bus.st_addr = 32'h90;
    @(negedge clk);
    reset = 1'b0; bus.st_valid = 1'b0; bus.m_data_ack = 1'b0;
    checks++; if (bus.m_data_req !== 1'b0 || bus.count !== 3'd0 || bus.st_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/1", bus.m_data_req, bus.count, bus.st_ready); end
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h84;
    #1;
    checks++; if (bus.ld_hazard !== 1'b0) begin errors++; $display("FAIL mid_hazard got=%b exp=0", bus.ld_hazard); end
    bus.ld_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_sb();
    test_sh();
    test_reject();
    test_hazard();
    test_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
